// File: rtl/instruction_fetch_unit.sv
// Fetch stage: owns the PC, fetches over a req/ack instruction memory port and
// holds each instruction for the decoder until it is consumed.
module instruction_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0040_0000
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        stall_in,
  input  logic        branch_in,
  input  logic        zero_in,
  input  logic        jump_in,
  input  logic [15:0] branch_imm_in,
  input  logic [25:0] jump_target_in,
  output logic        imem_req_out,
  output logic [31:0] imem_addr_out,
  input  logic        imem_ack_in,
  input  logic [31:0] imem_data_in,
  output logic [31:0] instr_out,
  output logic        instr_valid_out,
  output logic [5:0]  op_out,
  output logic [5:0]  func_out,
  output logic [31:0] pc_out,
  output logic [31:0] pc_plus4_out
);

  localparam int unsigned XLEN  = 32;
  localparam int unsigned IMM_W = 16;
  localparam int unsigned SEXT_W = XLEN - IMM_W - 2;
  localparam logic [XLEN-1:0] RESET_PC_ALIGNED = {RESET_PC[XLEN-1:2], 2'b00};

  typedef enum logic {
    FETCH = 1'b0,
    VALID = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [XLEN-1:0]  pc_q, pc_d, pc_plus4, branch_off;
  logic [XLEN-1:0]  instr_q;
  logic             capture, consume;

  // State register
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) state_q <= FETCH;
    else        state_q <= state_d;
  end

  // Next state; ack only matters while fetching, stall only while presenting
  always_comb begin
    state_d = state_q;
    capture = 1'b0;
    consume = 1'b0;
    unique case (state_q)
      FETCH: begin
        if (imem_ack_in) begin
          capture = 1'b1;
          state_d = VALID;
        end
      end
      VALID: begin
        if (!stall_in) begin
          consume = 1'b1;
          state_d = FETCH;
        end
      end
      default: state_d = FETCH;
    endcase
  end

  // Next PC: jump beats taken branch beats sequential
  always_comb begin
    pc_plus4   = pc_q + XLEN'(4);
    branch_off = {{SEXT_W{branch_imm_in[IMM_W-1]}}, branch_imm_in, 2'b00};
    pc_d       = pc_plus4;
    if (jump_in)                   pc_d = {pc_plus4[XLEN-1:28], jump_target_in, 2'b00};
    else if (branch_in && zero_in) pc_d = pc_plus4 + branch_off;
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      pc_q    <= RESET_PC_ALIGNED;
      instr_q <= '0;
    end else begin
      if (capture) instr_q <= imem_data_in;
      if (consume) pc_q    <= pc_d;
    end
  end

  // Request is gated by reset so it drops the instant reset asserts
  assign imem_req_out    = (state_q == FETCH) && !rst_in;
  assign imem_addr_out   = pc_q;
  assign instr_out       = instr_q;
  assign instr_valid_out = (state_q == VALID);
  assign op_out          = instr_q[31:26];
  assign func_out        = instr_q[5:0];
  assign pc_out          = pc_q;
  assign pc_plus4_out    = pc_plus4;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Scoreboard bench for instruction_fetch_unit: driver pushes expected fetch
// addresses and presented PCs; a monitor pops and compares as the DUT emits them.
module tb_instruction_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_in = 1'b1;
  logic        stall_in = 1'b1;
  logic        branch_in = 1'b0, zero_in = 1'b0, jump_in = 1'b0;
  logic [15:0] branch_imm_in = '0;
  logic [25:0] jump_target_in = '0;
  logic        imem_req_out, imem_ack_in = 1'b0;
  logic [31:0] imem_addr_out, imem_data_in = '0;
  logic [31:0] instr_out, pc_out, pc_plus4_out;
  logic        instr_valid_out;
  logic [5:0]  op_out, func_out;

  logic        w_req, w_valid;
  logic [31:0] w_addr, w_instr, w_pc, w_pc4;
  logic [5:0]  w_op, w_func;

  int pass_cnt = 0;
  int total_cnt = 0;
  int ack_delay = 0;
  int wait_cnt = 0;
  bit spurious = 1'b0;

  logic [31:0] exp_addr_q[$];
  logic [31:0] exp_pc_q[$];

  always #5 clk = ~clk;

  instruction_fetch_unit #(.RESET_PC(32'h0040_0000)) dut (
    .clk_in(clk), .rst_in(rst_in), .stall_in(stall_in),
    .branch_in(branch_in), .zero_in(zero_in), .jump_in(jump_in),
    .branch_imm_in(branch_imm_in), .jump_target_in(jump_target_in),
    .imem_req_out(imem_req_out), .imem_addr_out(imem_addr_out),
    .imem_ack_in(imem_ack_in), .imem_data_in(imem_data_in),
    .instr_out(instr_out), .instr_valid_out(instr_valid_out),
    .op_out(op_out), .func_out(func_out),
    .pc_out(pc_out), .pc_plus4_out(pc_plus4_out)
  );

  // Misaligned reset vector at the top of the address space, zero-wait memory
  instruction_fetch_unit #(.RESET_PC(32'hFFFF_FFFF)) u_wrap (
    .clk_in(clk), .rst_in(rst_in), .stall_in(1'b0),
    .branch_in(1'b0), .zero_in(1'b0), .jump_in(1'b0),
    .branch_imm_in(16'h0000), .jump_target_in(26'h0000000),
    .imem_req_out(w_req), .imem_addr_out(w_addr),
    .imem_ack_in(w_req), .imem_data_in(32'h0000_0000),
    .instr_out(w_instr), .instr_valid_out(w_valid),
    .op_out(w_op), .func_out(w_func),
    .pc_out(w_pc), .pc_plus4_out(w_pc4)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] addr);
    if (addr == 32'h0040_0000) return 32'h2008_0005;
    return 32'h8C00_0000 | {16'h0000, addr[15:0]};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
  endtask

  // Memory model: configurable wait states, optional spurious ack
  always @(negedge clk) begin
    #2;
    if (spurious) begin
      imem_ack_in  = 1'b1;
      imem_data_in = 32'hDEAD_BEEF;
    end else if (imem_req_out) begin
      if (wait_cnt == ack_delay) begin
        imem_ack_in  = 1'b1;
        imem_data_in = mem_word(imem_addr_out);
        wait_cnt     = 0;
      end else begin
        imem_ack_in  = 1'b0;
        imem_data_in = 32'h0BAD_0BAD;
        wait_cnt++;
      end
    end else begin
      imem_ack_in = 1'b0;
      wait_cnt    = 0;
    end
  end

  // Monitor: new request and new valid instruction each pop one expectation
  initial begin
    logic req_prev = 1'b0;
    logic valid_prev = 1'b0;
    logic [31:0] e;
    forever begin
      @(negedge clk);
      #1;
      if (imem_req_out && !req_prev) begin
        chk("fetch_q_has_entry", 32'(exp_addr_q.size() > 0), 32'd1);
        if (exp_addr_q.size() > 0) begin
          e = exp_addr_q.pop_front();
          chk("fetch_addr", imem_addr_out, e);
        end
      end
      if (instr_valid_out && !valid_prev) begin
        chk("instr_q_has_entry", 32'(exp_pc_q.size() > 0), 32'd1);
        if (exp_pc_q.size() > 0) begin
          e = exp_pc_q.pop_front();
          chk("pc_out", pc_out, e);
          chk("pc_plus4_out", pc_plus4_out, e + 32'd4);
          chk("instr_out", instr_out, mem_word(e));
          chk("op_out", 32'(op_out), 32'(mem_word(e) >> 26));
          chk("func_out", 32'(func_out), 32'(mem_word(e) & 32'h3F));
        end
      end
      req_prev   = imem_req_out;
      valid_prev = instr_valid_out;
    end
  end

  // Wrap instance: aligned reset vector and 0xFFFFFFFC + 4 -> 0
  initial begin
    @(negedge rst_in);
    #1;
    chk("wrap_first_req", 32'(w_req), 32'd1);
    chk("wrap_first_addr", w_addr, 32'hFFFF_FFFC);
    @(negedge clk);
    #1;
    chk("wrap_valid", 32'(w_valid), 32'd1);
    chk("wrap_pc_plus4", w_pc4, 32'h0000_0000);
    @(negedge clk);
    #1;
    chk("wrap_next_addr", w_addr, 32'h0000_0000);
  end

  task automatic wait_valid();
    int n = 0;
    while (!instr_valid_out && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("valid_timeout", 32'(instr_valid_out), 32'd1);
  endtask

  task automatic consume(input logic [31:0] nxt, input logic br, input logic zr,
                         input logic jp, input logic [15:0] imm, input logic [25:0] tgt);
    wait_valid();
    branch_in      = br;
    zero_in        = zr;
    jump_in        = jp;
    branch_imm_in  = imm;
    jump_target_in = tgt;
    exp_addr_q.push_back(nxt);
    exp_pc_q.push_back(nxt);
    stall_in = 1'b0;
    @(negedge clk);
    stall_in  = 1'b1;
    branch_in = 1'b0;
    zero_in   = 1'b0;
    jump_in   = 1'b0;
  endtask

  initial begin
    int n;
    #100_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    exp_addr_q.push_back(32'h0040_0000);
    exp_pc_q.push_back(32'h0040_0000);
    repeat (3) @(negedge clk);
    #1;
    chk("rst_req", 32'(imem_req_out), 32'd0);
    chk("rst_valid", 32'(instr_valid_out), 32'd0);
    chk("rst_instr", instr_out, 32'h0);
    chk("rst_op_func", 32'({op_out, func_out}), 32'h0);
    chk("rst_pc", pc_out, 32'h0040_0000);
    chk("rst_wrap_pc", w_pc, 32'hFFFF_FFFC);
    @(negedge clk);
    rst_in = 1'b0;

    // First instruction: decoder fields
    wait_valid();
    #1;
    chk("t1_op", 32'(op_out), 32'h08);
    chk("t1_func", 32'(func_out), 32'h05);
    consume(32'h0040_0004, 1'b0, 1'b0, 1'b0, 16'h0, 26'h0);

    // Stall for 3 cycles with spurious acks arriving
    wait_valid();
    spurious = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      chk("stall_instr", instr_out, mem_word(32'h0040_0004));
      chk("stall_pc", pc_out, 32'h0040_0004);
      chk("stall_valid", 32'(instr_valid_out), 32'd1);
      chk("stall_req", 32'(imem_req_out), 32'd0);
    end
    spurious = 1'b0;
    consume(32'h0040_0008, 1'b0, 1'b0, 1'b0, 16'h0, 26'h0);

    // Branch taken backwards, then not taken
    consume(32'h0040_000C, 1'b0, 1'b0, 1'b0, 16'h0, 26'h0);
    consume(32'h0040_0010, 1'b0, 1'b0, 1'b0, 16'h0, 26'h0);
    consume(32'h0040_000C, 1'b1, 1'b1, 1'b0, 16'hFFFE, 26'h0);
    consume(32'h0040_0010, 1'b0, 1'b0, 1'b0, 16'h0, 26'h0);
    consume(32'h0040_0014, 1'b1, 1'b0, 1'b0, 16'hFFFE, 26'h0);

    // Jumps, including jump over a simultaneous taken branch
    consume(32'h0040_0020, 1'b0, 1'b0, 1'b1, 16'h0, 26'h0100008);
    consume(32'h0040_0040, 1'b0, 1'b0, 1'b1, 16'h0, 26'h0100010);
    consume(32'h0040_0040, 1'b1, 1'b1, 1'b1, 16'h0004, 26'h0100010);

    // Four wait states
    ack_delay = 4;
    consume(32'h0040_0044, 1'b0, 1'b0, 1'b0, 16'h0, 26'h0);
    n = 0;
    for (int i = 0; i < 20; i++) begin
      #1;
      if (instr_valid_out) break;
      chk("wait_req", 32'(imem_req_out), 32'd1);
      chk("wait_addr", imem_addr_out, 32'h0040_0044);
      n++;
      @(negedge clk);
    end
    chk("wait_cycles", 32'(n), 32'd5);

    // Reset in the middle of a memory wait
    ack_delay = 10;
    consume(32'h0040_0048, 1'b0, 1'b0, 1'b0, 16'h0, 26'h0);
    repeat (2) @(negedge clk);
    chk("pre_rst_req", 32'(imem_req_out), 32'd1);
    rst_in = 1'b1;
    #1;
    chk("midrst_req_drop", 32'(imem_req_out), 32'd0);
    chk("midrst_pc", pc_out, 32'h0040_0000);
    chk("abandoned_instr", 32'(exp_pc_q.size()), 32'd1);
    exp_pc_q.delete();
    exp_addr_q.push_back(32'h0040_0000);
    exp_pc_q.push_back(32'h0040_0000);
    ack_delay = 0;
    repeat (2) @(negedge clk);
    rst_in = 1'b0;
    consume(32'h0040_0004, 1'b0, 1'b0, 1'b0, 16'h0, 26'h0);
    wait_valid();
    @(negedge clk);
    #2;
    chk("addr_q_drained", 32'(exp_addr_q.size()), 32'd0);
    chk("pc_q_drained", 32'(exp_pc_q.size()), 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/instruction_fetch_unit.md
Name: instruction_fetch_unit

Overview:
- Sequential fetch stage that sits directly upstream of the instruction decoder/control unit.
- Owns the program counter and fetches 32-bit MIPS instructions over a req/ack instruction-memory handshake.
- Presents the opcode and funct fields to the control unit for decode.
- Consumes the decoder's branch/jump decisions, plus the ALU zero flag, to select the next PC.

Parameters:
RESET_PC, 32'h0040_0000, PC loaded on reset; bits [1:0] ignored (forced 0)

Ports:
clk_in  input  1  single clock; all state on rising edge
rst_in  input  1  reset, asynchronous, active-high
stall_in  input  1  downstream not ready; holds the presented instruction
branch_in  input  1  branch decision for the presented instruction (from control unit)
zero_in  input  1  ALU zero flag for the presented instruction
jump_in  input  1  jump decision for the presented instruction (from control unit)
branch_imm_in  input  16  branch offset in words, signed
jump_target_in  input  26  jump target field
imem_req_out  output  1  instruction-memory request
imem_addr_out  output  32  fetch address
imem_ack_in  input  1  memory returns data this cycle
imem_data_in  input  32  fetched instruction, valid when imem_ack_in=1
instr_out  output  32  registered instruction
instr_valid_out  output  1  instr_out/pc_out valid
op_out  output  6  instr_out[31:26], wired to decoder op input
func_out  output  6  instr_out[5:0], wired to decoder func input
pc_out  output  32  address of instr_out
pc_plus4_out  output  32  pc_out + 4

Behaviour:
- Reset (async, while rst_in=1):
  - pc_reg = {RESET_PC[31:2], 2'b00}; state = FETCH.
  - imem_req_out = 0; instr_out = 0; instr_valid_out = 0.
  - op_out = 0; func_out = 0; pc_out = RESET_PC aligned.
  - imem_ack_in is ignored.
- State FETCH:
  - imem_req_out = 1; imem_addr_out = pc_reg.
  - Address held stable until ack.
  - On imem_ack_in=1: instr_out <= imem_data_in, go to VALID.
  - Ack may arrive in the same cycle as the request (zero-wait memory).
  - instr_valid_out = 0 throughout FETCH.
- State VALID:
  - instr_valid_out = 1; imem_req_out = 0.
  - If stall_in=1: stay in VALID. instr_out and pc_out are held, and branch/jump/zero inputs are ignored.
  - If stall_in=0: the instruction is consumed. pc_reg <= next_pc and go to FETCH.
- next_pc priority:
  - jump_in=1: {pc_plus4[31:28], jump_target_in, 2'b00}.
  - else branch_in & zero_in: pc_plus4 + (sign_extend(branch_imm_in) << 2).
  - else: pc_plus4.
  - Jump wins when jump_in and branch_in are both asserted.
- Arithmetic and timing:
  - 32-bit modulo arithmetic; 0xFFFF_FFFC + 4 wraps to 0x0000_0000. No exception.
  - pc_reg[1:0] is always 00.
  - Throughput: minimum 2 cycles per instruction (FETCH with same-cycle ack, then VALID). Each memory wait state adds 1 cycle.
- Reset mid-operation:
  - Reset during FETCH or VALID drops imem_req_out immediately.
  - The memory must abandon any outstanding request on reset.
  - The first request after reset release is at RESET_PC in the first clock after rst_in falls.
- Spurious signals:
  - imem_ack_in outside FETCH is ignored.
  - stall_in in FETCH has no effect; the fetch completes and stall applies in VALID.
- pc_plus4_out is combinational from pc_out.
- op_out and func_out are combinational slices of instr_out.

Test Plan:
1. Reset then release, RESET_PC=0x00400000, ack same cycle with 0x20080005.
   - Expect imem_addr_out=0x00400000 with req=1.
   - Next cycle: valid=1, op_out=0x08, func_out=0x05, pc_out=0x00400000.
   - With stall_in=0, following request address = 0x00400004.
2. Hold stall_in=1 for 3 cycles in VALID.
   - Expect instr_out, pc_out, valid=1 stable and imem_req_out=0.
   - Release stall_in: next request at pc+4.
3. Branch at pc_out=0x00400010, imm=0xFFFE:
   - branch_in=1, zero_in=1 -> next request 0x0040000C.
   - Repeat with zero_in=0 -> 0x00400014.
4. Jump at pc_out=0x00400020, jump_target_in=26'h0100010 -> next request 0x00400040.
   - Same with branch_in=1 and zero_in=1 also asserted -> still 0x00400040.
5. Memory ack delayed 4 cycles.
   - Expect req=1 and address unchanged for 5 cycles, valid=0.
   - valid=1 the cycle after ack.
6. Reset and wrap boundaries:
   - Assert rst_in mid-wait -> req drops the same cycle. After release, request at RESET_PC.
   - Sequential fetch from 0xFFFFFFFC -> next request 0x00000000.
